// File: rtl/midi_msg_decoder_pkg.sv
// Shared definitions for the MIDI message decoder: command codes, bus width,
// FSM state encoding and the status-byte classification record.
// Command code 0 (NONE) is the reset value of the command field and never pulses.
package midi_msg_decoder_pkg;

    localparam int MIDI_CMD_SIZE = 4;

    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NONE         = 4'd0;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF     = 4'd1;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON      = 4'd2;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_AFTERTOUCH   = 4'd3;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC           = 4'd4;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PROG_CHANGE  = 4'd5;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_PRESSURE  = 4'd6;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND   = 4'd7;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS_COMMON   = 4'd8;
    localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYS_REALTIME = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D0 = 2'd1,
        ST_WAIT_D1 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_t;

    // Result of classifying a status byte: command code and number of data bytes.
    typedef struct packed {
        logic [MIDI_CMD_SIZE-1:0] cmd;
        logic [1:0]               cnt;
    } status_info_t;

endpackage

// File: rtl/midi_msg_decoder.sv
// Purpose : parse a raw MIDI byte stream into complete messages (running
//           status, interleaved real-time bytes, SysEx skipping).
// Latency : midi_rdy pulses 1 cycle after the byte_rdy of the completing byte.
// Backpressure: none; accepts one byte every cycle, never stalls.
// Ports   : clk/reset (sync, active-high); byte_rdy/byte_data from UART RX;
//           midi_rdy pulse with midi_cmd/midi_ch_sysn/midi_data0/midi_data1
//           held until the next pulse.
module midi_msg_decoder
    import midi_msg_decoder_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     byte_rdy,
    input  logic [7:0]               byte_data,
    output logic                     midi_rdy,
    output logic [MIDI_CMD_SIZE-1:0] midi_cmd,
    output logic [3:0]               midi_ch_sysn,
    output logic [6:0]               midi_data0,
    output logic [6:0]               midi_data1
);

    state_t       state;
    logic [7:0]   run_status;   // last channel status, reused for running status
    logic         run_vld;
    logic [7:0]   cur_status;   // status of the message being assembled
    logic [6:0]   d0;           // first data byte of the message being assembled
    status_info_t run_info;
    status_info_t cur_info;

    function automatic status_info_t lookup(input logic [7:0] s);
        status_info_t r;
        r.cmd = MIDI_CMD_NONE;
        r.cnt = 2'd0;
        case (s[7:4])
            4'h8: begin r.cmd = MIDI_CMD_NOTE_OFF;    r.cnt = 2'd2; end
            4'h9: begin r.cmd = MIDI_CMD_NOTE_ON;     r.cnt = 2'd2; end
            4'hA: begin r.cmd = MIDI_CMD_AFTERTOUCH;  r.cnt = 2'd2; end
            4'hB: begin r.cmd = MIDI_CMD_CC;          r.cnt = 2'd2; end
            4'hC: begin r.cmd = MIDI_CMD_PROG_CHANGE; r.cnt = 2'd1; end
            4'hD: begin r.cmd = MIDI_CMD_CH_PRESSURE; r.cnt = 2'd1; end
            4'hE: begin r.cmd = MIDI_CMD_PITCH_BEND;  r.cnt = 2'd2; end
            4'hF: begin
                case (s[3:0])
                    4'h1, 4'h3: begin r.cmd = MIDI_CMD_SYS_COMMON; r.cnt = 2'd1; end
                    4'h2:       begin r.cmd = MIDI_CMD_SYS_COMMON; r.cnt = 2'd2; end
                    4'h6:       begin r.cmd = MIDI_CMD_SYS_COMMON; r.cnt = 2'd0; end
                    default:    begin r.cmd = MIDI_CMD_NONE;       r.cnt = 2'd0; end
                endcase
            end
            default: begin r.cmd = MIDI_CMD_NONE; r.cnt = 2'd0; end
        endcase
        return r;
    endfunction

    // Generators treat NOTE_ON with zero velocity as a release.
    function automatic logic [MIDI_CMD_SIZE-1:0] final_cmd(
        input logic [MIDI_CMD_SIZE-1:0] cmd,
        input logic [6:0]               vel
    );
        return (cmd == MIDI_CMD_NOTE_ON && vel == 7'd0) ? MIDI_CMD_NOTE_OFF : cmd;
    endfunction

    assign run_info = lookup(run_status);
    assign cur_info = lookup(cur_status);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            run_status   <= 8'h00;
            run_vld      <= 1'b0;
            cur_status   <= 8'h00;
            d0           <= 7'd0;
            midi_rdy     <= 1'b0;
            midi_cmd     <= MIDI_CMD_NONE;
            midi_ch_sysn <= 4'd0;
            midi_data0   <= 7'd0;
            midi_data1   <= 7'd0;
        end else begin
            midi_rdy <= 1'b0;
            if (byte_rdy) begin
                if (byte_data[7:3] == 5'b11111) begin
                    // Real-time: emit only, decoder state is left untouched.
                    midi_rdy     <= 1'b1;
                    midi_cmd     <= MIDI_CMD_SYS_REALTIME;
                    midi_ch_sysn <= byte_data[3:0];
                    midi_data0   <= 7'd0;
                    midi_data1   <= 7'd0;
                end else if (byte_data[7]) begin
                    // Any other status abandons a partial message or leaves SysEx.
                    if (byte_data[7:4] != 4'hF) begin
                        run_status <= byte_data;
                        run_vld    <= 1'b1;
                        cur_status <= byte_data;
                        state      <= ST_WAIT_D0;
                    end else begin
                        case (byte_data[3:0])
                            4'h0: begin
                                run_vld <= 1'b0;
                                state   <= ST_SYSEX;
                            end
                            4'h7: state <= ST_IDLE;
                            4'h1, 4'h2, 4'h3: begin
                                run_vld    <= 1'b0;
                                cur_status <= byte_data;
                                state      <= ST_WAIT_D0;
                            end
                            4'h6: begin
                                run_vld      <= 1'b0;
                                state        <= ST_IDLE;
                                midi_rdy     <= 1'b1;
                                midi_cmd     <= MIDI_CMD_SYS_COMMON;
                                midi_ch_sysn <= 4'h6;
                                midi_data0   <= 7'd0;
                                midi_data1   <= 7'd0;
                            end
                            default: begin
                                run_vld <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        endcase
                    end
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (run_vld) begin
                                cur_status <= run_status;
                                if (run_info.cnt == 2'd1) begin
                                    midi_rdy     <= 1'b1;
                                    midi_cmd     <= run_info.cmd;
                                    midi_ch_sysn <= run_status[3:0];
                                    midi_data0   <= byte_data[6:0];
                                    midi_data1   <= 7'd0;
                                end else begin
                                    d0    <= byte_data[6:0];
                                    state <= ST_WAIT_D1;
                                end
                            end
                        end
                        ST_WAIT_D0: begin
                            if (cur_info.cnt == 2'd1) begin
                                midi_rdy     <= 1'b1;
                                midi_cmd     <= cur_info.cmd;
                                midi_ch_sysn <= cur_status[3:0];
                                midi_data0   <= byte_data[6:0];
                                midi_data1   <= 7'd0;
                                state        <= ST_IDLE;
                            end else begin
                                d0    <= byte_data[6:0];
                                state <= ST_WAIT_D1;
                            end
                        end
                        ST_WAIT_D1: begin
                            midi_rdy     <= 1'b1;
                            midi_cmd     <= final_cmd(cur_info.cmd, byte_data[6:0]);
                            midi_ch_sysn <= cur_status[3:0];
                            midi_data0   <= d0;
                            midi_data1   <= byte_data[6:0];
                            state        <= ST_IDLE;
                        end
                        default: ;  // SysEx payload is discarded
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/midi_msg_decoder.md
# midi_msg_decoder

Parses a raw MIDI byte stream (UART receiver output) into complete MIDI messages and presents them on the same `midi_rdy`/`midi_cmd`/`midi_ch_sysn`/`midi_data0`/`midi_data1` bus that the sound generators (`gen_sine` and siblings) consume. It handles running status, real-time bytes interleaved mid-message, and SysEx skipping. It sits between the MIDI UART RX and the generator fan-out in the synth top level.

## Interface
- No parameters. Command codes and width come from `globals.vh` (`MIDI_CMD_SIZE`, `MIDI_CMD_*`).
- Clock and reset: single clock domain; `reset` is synchronous and active-high.
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-high
- `byte_rdy`  in  1  one-cycle strobe; `byte_data` valid. At most one byte per cycle.
- `byte_data`  in  8  received MIDI byte
- `midi_rdy`  out  1  one-cycle pulse; message fields valid
- `midi_cmd`  out  `MIDI_CMD_SIZE`  decoded command code
- `midi_ch_sysn`  out  4  channel for channel messages; status low nibble for system messages
- `midi_data0`  out  7  first data byte, 0 if none
- `midi_data1`  out  7  second data byte, 0 if none

## Operation
- Status bytes (bit7 = 1) are classified as follows:
  - 0x8n–0xEn: channel message. Data-byte count is 2 for 8/9/A/B/E and 1 for C/D. Loads the running status.
  - 0xF0: enter SYSEX and clear the running status.
  - 0xF1 and 0xF3: 1 data byte. 0xF2: 2 data bytes. 0xF6: 0 data bytes, emitted immediately. All of these clear the running status. 0xF4/F5 are undefined: clear the running status and emit nothing.
  - 0xF7: leave SYSEX, no output.
  - 0xF8–0xFF: real-time. Emitted immediately as `MIDI_CMD_SYS_REALTIME` with ch_sysn = low nibble. State, partial data and running status are untouched. This holds inside SYSEX too.
- Command map: 8→NOTE_OFF, 9→NOTE_ON, A→AFTERTOUCH, B→CC, C→PROG_CHANGE, D→CH_PRESSURE, E→PITCH_BEND, F1–F6→SYS_COMMON.
- NOTE_ON with data1 = 0 is emitted as NOTE_OFF with data1 = 0.
- Data byte (bit7 = 0) handling:
  - In IDLE with a valid running status: acts as data0 of a new message.
  - In IDLE without a running status, or in SYSEX: discarded.
- A non-real-time status byte arriving mid-message abandons the partial message. No output is produced for it.
- State machine, with states IDLE, WAIT_D0, WAIT_D1, SYSEX:
  - IDLE → WAIT_D0 on a status byte needing data, or on a data byte under running status when 2 bytes are needed. In that running-status case the byte is stored as d0 and the state goes straight to WAIT_D1.
  - IDLE → emit on a 1-byte running-status data byte.
  - WAIT_D0 → WAIT_D1 (2-byte message) or emit → IDLE.
  - WAIT_D1 → emit → IDLE.
  - Any state → SYSEX on 0xF0. SYSEX → IDLE on 0xF7 or on any non-real-time status byte; that status byte is then processed normally.

## Timing
- Reset values: `midi_rdy` = 0, all fields = 0, state IDLE, running status invalid.
- Latency: `midi_rdy` asserts exactly 1 cycle after the `byte_rdy` cycle of the completing byte.
- `midi_rdy` is high for exactly 1 cycle. Fields hold their value until the next pulse.
- Back-to-back bytes on consecutive cycles are fully supported. No stall, no backpressure.
- A real-time byte emitted mid-message overwrites the fields for its own pulse only. The partial message keeps its internal d0 and completes with correct fields.
- Reset asserted mid-message: state, partial data and running status are dropped. A `midi_rdy` that would have fired in the reset cycle is suppressed.

## Structure
- Add to `globals.vh`: `MIDI_CMD_AFTERTOUCH`, `MIDI_CMD_CC`, `MIDI_CMD_PROG_CHANGE`, `MIDI_CMD_CH_PRESSURE`, `MIDI_CMD_PITCH_BEND`, `MIDI_CMD_SYS_COMMON`, `MIDI_CMD_SYS_REALTIME` alongside the existing `MIDI_CMD_NOTE_ON`/`NOTE_OFF`.
- Add state encodings as local parameters.
- Single module, no sub-modules. The status→(cmd, data-count) lookup is one combinational function inside it.

## Test plan
- 90 3C 64 → one pulse, 1 cycle after 64: NOTE_ON, ch 0, d0 0x3C, d1 0x64.
- 91 40 20 41 21 → two pulses: NOTE_ON ch 1 (0x40, 0x20) then (0x41, 0x21), via running status.
- 90 3C F8 64 → REALTIME ch_sysn 8 one cycle after F8, then NOTE_ON ch 0 (0x3C, 0x64) after 64.
- 93 3C 00 → NOTE_OFF, ch 3, d0 0x3C, d1 0; C5 07 → PROG_CHANGE, ch 5, d0 0x07, d1 0.
- F0 01 02 F7 3C 64 → no pulses; running status was cleared. Also 3C with no prior status → no pulse.
- 90 3C, reset 1 cycle, then 64 → no pulse; then E2 00 40 → PITCH_BEND, ch 2, d0 0, d1 0x40.
